// File: rtl/teclado_scan_fifo_pkg.sv
// Shared types and sizing helpers for the keypad scanner with key-code queue.
// KEY_RELEASE_EN (optional macro) adds a release flag as the key-code MSB.
package teclado_scan_fifo_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } scan_state_t;

    // Wide enough for the largest 8x8 matrix.
    localparam int MAX_CODE_W = 6;

    typedef struct packed {
        logic                  rel;
        logic [MAX_CODE_W-1:0] code;
    } key_evt_t;

`ifdef KEY_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    function automatic int code_width(input int rows, input int cols);
        int n = rows * cols;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/teclado_scan_fifo_if.sv
// Key-code output port: queue head with valid/ready, plus held/overflow status.
// Master drives the queue side, slave is the consumer.
interface teclado_scan_fifo_if #(
    parameter int KW = 4
);
    logic [KW-1:0] key_code;
    logic          key_valid;
    logic          key_ready;
    logic          key_held;
    logic          overflow;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overflow,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overflow,
        output key_ready
    );
endinterface

// File: rtl/teclado_scan_fifo_fifo.sv
// Synchronous FIFO with head read straight from storage; push visible one cycle later.
// Full push is dropped (overflow pulse next cycle) unless a pop happens in the same cycle.
module teclado_scan_fifo_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         overflow_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [NW-1:0] cnt_q;
    logic          ovf_q;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == NW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the same cycle, so a full queue still accepts the push.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + NW'(1);
                2'b01:   cnt_q <= cnt_q - NW'(1);
                default: cnt_q <= cnt_q;
            endcase
            ovf_q <= push_i && full && !do_pop;
        end
    end

    assign head_o     = empty_o ? '0 : mem_q[rd_q];
    assign overflow_o = ovf_q;

endmodule

// File: rtl/teclado_scan_fifo.sv
// Keypad matrix scanner + debouncer feeding a key-code FIFO; rows pass a 2-flop synchroniser.
// Scanning never stalls on the consumer; KEY_RELEASE_EN also queues release events.
module teclado_scan_fifo
    import teclado_scan_fifo_pkg::*;
#(
    parameter int N_ROWS       = 4,
    parameter int N_COLS       = 4,
    parameter int SETTLE_CYC   = 270,
    parameter int DEBOUNCE_CYC = 270000,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_ROWS-1:0]   fil_i,
    output logic [N_COLS-1:0]   col_o,
    teclado_scan_fifo_if.master key_if
);
    localparam int CW      = code_width(N_ROWS, N_COLS);
    localparam int KW      = CW + (REL_EN ? 1 : 0);
    localparam int IW      = idx_width(N_COLS);
    localparam int RW      = idx_width(N_ROWS);
    localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [IW-1:0]    LAST_COL    = IW'(N_COLS - 1);

    logic [N_ROWS-1:0] sync1_q;
    logic [N_ROWS-1:0] sync2_q;
    scan_state_t       state_q;
    logic [IW-1:0]     idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     code_q;
    logic              held_q;
    logic [N_COLS-1:0] col_q;

    logic              any_low;
    logic [RW-1:0]     first_row;
    logic              row_hi;
    logic              settle_done;
    logic              deb_done;
    logic [IW-1:0]     idx_nxt;
    logic [CW-1:0]     code_new;
    logic              push_vld;
    key_evt_t          push_evt;
    logic [KW-1:0]     push_dat;
    logic              fifo_empty;

    function automatic logic [N_COLS-1:0] col_drive(input logic [IW-1:0] i);
        logic [N_COLS-1:0] c;
        c    = '1;
        c[i] = 1'b0;
        return c;
    endfunction

    always_comb begin
        any_low   = 1'b0;
        first_row = '0;
        // Walk downwards so the lowest low row wins.
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (!sync2_q[r]) begin
                any_low   = 1'b1;
                first_row = RW'(r);
            end
        end
        row_hi      = sync2_q[row_q];
        settle_done = (cnt_q == SETTLE_LAST);
        deb_done    = (cnt_q == DEB_LAST);
        idx_nxt     = (idx_q == LAST_COL) ? '0 : idx_q + IW'(1);
        code_new    = CW'(int'(first_row) * N_COLS + int'(idx_q));

        push_vld = 1'b0;
        push_evt = '0;
        if (state_q == DEBOUNCE && !row_hi && deb_done) begin
            push_vld      = 1'b1;
            push_evt.code = MAX_CODE_W'(code_q);
        end
`ifdef KEY_RELEASE_EN
        if (state_q == HOLD && row_hi && deb_done) begin
            push_vld      = 1'b1;
            push_evt.rel  = 1'b1;
            push_evt.code = MAX_CODE_W'(code_q);
        end
`endif
    end

`ifdef KEY_RELEASE_EN
    assign push_dat = {push_evt.rel, CW'(push_evt.code)};
`else
    assign push_dat = KW'(push_evt);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            state_q <= SCAN;
            idx_q   <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            code_q  <= '0;
            held_q  <= 1'b0;
            col_q   <= '1;
        end else begin
            sync1_q <= fil_i;
            sync2_q <= sync1_q;
            // Later assignments in the case override this when the column advances.
            col_q   <= col_drive(idx_q);
            case (state_q)
                SCAN: begin
                    if (settle_done) begin
                        cnt_q <= '0;
                        if (any_low) begin
                            row_q   <= first_row;
                            code_q  <= code_new;
                            state_q <= DEBOUNCE;
                        end else begin
                            idx_q <= idx_nxt;
                            col_q <= col_drive(idx_nxt);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_hi) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        idx_q   <= idx_nxt;
                        col_q   <= col_drive(idx_nxt);
                    end else if (deb_done) begin
                        state_q <= HOLD;
                        held_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!row_hi) begin
                        cnt_q <= '0;
                    end else if (deb_done) begin
                        state_q <= SCAN;
                        held_q  <= 1'b0;
                        cnt_q   <= '0;
                        idx_q   <= idx_nxt;
                        col_q   <= col_drive(idx_nxt);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= SCAN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    teclado_scan_fifo_fifo #(
        .W     (KW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_vld),
        .push_dat_i (push_dat),
        .pop_i      (key_if.key_ready),
        .head_o     (key_if.key_code),
        .empty_o    (fifo_empty),
        .overflow_o (key_if.overflow)
    );

    assign col_o            = col_q;
    assign key_if.key_valid = !fifo_empty;
    assign key_if.key_held  = held_q;

endmodule
